// File: rtl/imm_field_encoder_if.sv
// rtl/imm_field_encoder_if.sv - stream and status bundle for the immediate field encoder
interface imm_field_encoder_if #(
    parameter int IW    = 34,
    parameter int VW    = 24,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IW-1:0]    in_word;
    logic [1:0]       in_immsrc;
    logic [VW-1:0]    in_value;
    logic             out_valid;
    logic             out_ready;
    logic [IW-1:0]    out_word;
    logic             out_err;
    logic [CNT_W-1:0] err_count;
    logic             clr_err;

    modport master (
        output in_valid, in_word, in_immsrc, in_value, out_ready, clr_err,
        input  in_ready, out_valid, out_word, out_err, err_count
    );

    modport slave (
        input  in_valid, in_word, in_immsrc, in_value, out_ready, clr_err,
        output in_ready, out_valid, out_word, out_err, err_count
    );
endinterface

// File: rtl/imm_field_encoder.sv
// rtl/imm_field_encoder.sv - packs a range-checked signed immediate into an instruction word
module imm_field_encoder #(
    parameter int IW    = 34,
    parameter int VW    = 24,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    imm_field_encoder_if.slave bus
);
    // Widest field is 16 bits, so only that much of the value is carried past S1.
    localparam int MAXW = 16;

    logic             s1_valid;
    logic [IW-1:0]    s1_word;
    logic [1:0]       s1_immsrc;
    logic [MAXW-1:0]  s1_imm;
    logic             s1_fits;

    logic             s2_valid;
    logic [IW-1:0]    s2_word;
    logic             s2_err;
    logic [CNT_W-1:0] err_cnt;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic             in_fits;
    logic [IW-1:0]    packed_word;

    assign s2_adv   = !s2_valid || bus.out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_valid && bus.out_ready;

    assign bus.in_ready  = !s1_valid || s2_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_word  = s2_word;
    assign bus.out_err   = s2_err;
    assign bus.err_count = err_cnt;

    // Representable when every bit from the field's sign bit upward agrees.
    always_comb begin
        in_fits = 1'b1;
        case (bus.in_immsrc)
            2'b00:   in_fits = (&bus.in_value[VW-1:9])  || !(|bus.in_value[VW-1:9]);
            2'b01:   in_fits = (&bus.in_value[VW-1:15]) || !(|bus.in_value[VW-1:15]);
            2'b10:   in_fits = (&bus.in_value[VW-1:1])  || !(|bus.in_value[VW-1:1]);
            default: in_fits = 1'b1;
        endcase
    end

    always_comb begin
        packed_word = s1_word;
        case (s1_immsrc)
            2'b00:   packed_word[9:0]  = s1_imm[9:0];
            2'b01:   packed_word[15:0] = s1_imm[15:0];
            2'b10:   packed_word[1:0]  = s1_imm[1:0];
            default: packed_word       = s1_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_word   <= '0;
            s1_immsrc <= 2'b11;
            s1_imm    <= '0;
            s1_fits   <= 1'b1;
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_word   <= bus.in_word;
                s1_immsrc <= bus.in_immsrc;
                s1_imm    <= bus.in_value[MAXW-1:0];
                s1_fits   <= in_fits;
            end else if (s1_adv) begin
                s1_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= packed_word;
                s2_err  <= !s1_fits;
            end
        end
    end

    // Clear wins over a coincident errored handshake; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (bus.clr_err) begin
            err_cnt <= '0;
        end else if (out_fire && s2_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule
